// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge core: window handshake, raster position, border flag and output framing.
// Optional stall counter enabled by defining SOBEL_FRAME_CTRL_STALL_CNT_EN.
module sobel_frame_ctrl #(
  parameter int COL_W = 10,
  parameter int ROW_W = 10,
  parameter int LAT   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             core_on_edge,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err,
  output logic [31:0]      stall_count
);

  localparam int DCW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [COL_W-1:0] r_width, r_col;
  logic [ROW_W-1:0] r_height, r_row;
  logic [DCW-1:0]   r_drain_cnt;
  logic [LAT:1]     r_pv, r_pl;
  logic [LAT-1:1]   r_pe;
  logic             r_cfg_err;
  logic             w_acc, w_cfg_bad, w_start_ok, w_col_end, w_row_end, w_edge, w_frame_end;

  assign w_cfg_bad   = (width < COL_W'(3)) || (height < ROW_W'(3));
  assign w_start_ok  = (r_state == S_IDLE) && start && !w_cfg_bad;
  assign w_col_end   = (r_col == r_width - COL_W'(1));
  assign w_row_end   = (r_row == r_height - ROW_W'(1));
  assign w_acc       = in_valid && in_ready;
  assign w_edge      = (r_col == '0) || w_col_end || (r_row == '0) || w_row_end;
  assign w_frame_end = w_acc && w_col_end && w_row_end;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every register samples the pre-edge values of the others.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_RUN;
      S_RUN:   if (w_frame_end) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DCW'(LAT - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_RUN:   begin in_ready = 1'b1; busy = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: frame geometry is always loaded by an accepted start before use, so it carries no reset.
  always_ff @(posedge clock) begin
    if (w_start_ok) begin
      r_width  <= width;
      r_height <= height;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_drain_cnt <= '0;
      r_pv        <= '0;
      r_pe        <= '0;
      r_pl        <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err   <= (r_state == S_IDLE) && start && w_cfg_bad;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DCW'(1) : '0;
      // Bubbles shift in with valid=0 so downstream timing tracks the accept cycle.
      r_pv[1] <= w_acc;
      r_pe[1] <= w_acc && w_edge;
      r_pl[1] <= w_frame_end;
      for (int i = 2; i <= LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
      for (int i = 2; i < LAT; i++) r_pe[i] <= r_pe[i-1];
      if (w_start_ok) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_acc) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign col          = r_col;
  assign row          = r_row;
  assign cfg_err      = r_cfg_err;
  assign core_on_edge = r_pe[LAT-1] && r_pv[LAT-1];
  assign out_valid    = r_pv[LAT];
  assign out_last     = r_pl[LAT] && r_pv[LAT];

`ifdef SOBEL_FRAME_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (reset || w_start_ok)
      r_stall_cnt <= '0;
    else if ((r_state == S_RUN) && !in_valid && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed self-checking bench for sobel_frame_ctrl (COL_W=ROW_W=10, LAT=2).
module tb_sobel_frame_ctrl;
  localparam int COL_W = 10;
  localparam int ROW_W = 10;
  localparam int LAT   = 2;
`ifdef SOBEL_FRAME_CTRL_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [COL_W-1:0] width = '0;
  logic [ROW_W-1:0] height = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             core_on_edge, out_valid, out_last, busy, frame_done, cfg_err;
  logic [31:0]      stall_count;

  int total = 0;
  int bad   = 0;

  sobel_frame_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .width(width), .height(height),
    .in_valid(in_valid), .in_ready(in_ready), .col(col), .row(row),
    .core_on_edge(core_on_edge), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    @(negedge clock);
    total++;
    if ({in_ready, col, row, core_on_edge, out_valid, out_last, busy, frame_done, cfg_err, stall_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b col=%0d row=%0d edge=%b ov=%b last=%b busy=%b done=%b err=%b stall=%0d, want all 0",
               in_ready, col, row, core_on_edge, out_valid, out_last, busy, frame_done, cfg_err, stall_count);
    end
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_cfg_err(input int w, input int h);
    logic [2:0] obs, exp_v;
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      start  = (k == 0);
      width  = COL_W'(w);
      height = ROW_W'(h);
      @(negedge clock);
      obs   = {cfg_err, busy, in_ready};
      exp_v = {(k == 1), 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL cfg_err w=%0d h=%0d cyc=%0d: got {err,busy,ready}=%b want %b", w, h, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_frame_4x3();
    logic [5:0] obs, exp_v;
    for (int k = 0; k <= 17; k++) begin
      next_cycle();
      start    = (k == 0);
      width    = 10'd4;
      height   = 10'd3;
      in_valid = (k >= 1 && k <= 12);
      @(negedge clock);
      obs   = {in_ready, busy, out_valid, core_on_edge, out_last, frame_done};
      exp_v = {(k >= 1 && k <= 12), (k >= 1 && k <= 14), (k >= 3 && k <= 14),
               (k >= 2 && k <= 13 && k != 7 && k != 8), (k == 14), (k == 15)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL frame4x3 cyc=%0d: got {ready,busy,ov,edge,last,done}=%b want %b", k, obs, exp_v);
      end
      if (k >= 1 && k <= 12) begin
        total++;
        if (col !== COL_W'((k - 1) % 4) || row !== ROW_W'((k - 1) / 4)) begin
          bad++;
          $display("FAIL frame4x3_pos cyc=%0d: got col=%0d row=%0d want col=%0d row=%0d", k, col, row, (k - 1) % 4, (k - 1) / 4);
        end
      end
      if (k == 13) begin
        total++;
        if (col !== '0 || row !== '0) begin
          bad++;
          $display("FAIL frame4x3_wrap: got col=%0d row=%0d want 0 0", col, row);
        end
      end
      if (k == 15) begin
        total++;
        if (stall_count !== 32'd0) begin
          bad++;
          $display("FAIL frame4x3_stall: got %0d want 0", stall_count);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [4:0] obs, exp_v;
    int         ov_cnt;
    ov_cnt = 0;
    for (int k = 0; k <= 28; k++) begin
      next_cycle();
      start    = (k == 0);
      width    = 10'd4;
      height   = 10'd3;
      in_valid = (k >= 1 && k <= 23 && (k % 2 == 1));
      @(negedge clock);
      if (out_valid) ov_cnt++;
      obs   = {busy, out_valid, core_on_edge, out_last, frame_done};
      exp_v = {(k >= 1 && k <= 25), (k >= 3 && k <= 25 && (k % 2 == 1)),
               (k >= 2 && k <= 24 && (k % 2 == 0) && k != 12 && k != 14), (k == 25), (k == 26)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL gaps cyc=%0d: got {busy,ov,edge,last,done}=%b want %b", k, obs, exp_v);
      end
      if (k >= 1 && k <= 23) begin
        total++;
        if (col !== COL_W'((k / 2) % 4) || row !== ROW_W'((k / 2) / 4)) begin
          bad++;
          $display("FAIL gaps_pos cyc=%0d: got col=%0d row=%0d want col=%0d row=%0d", k, col, row, (k / 2) % 4, (k / 2) / 4);
        end
      end
      if (k == 26 || k == 28) begin
        total++;
        if (stall_count !== (STALL_EN ? 32'd11 : 32'd0)) begin
          bad++;
          $display("FAIL gaps_stall cyc=%0d: got %0d want %0d", k, stall_count, STALL_EN ? 11 : 0);
        end
      end
    end
    total++;
    if (ov_cnt != 12) begin
      bad++;
      $display("FAIL gaps_ov_count: got %0d want 12", ov_cnt);
    end
  endtask

  task automatic run_frame_cont(input int w, input int h);
    int n, k, last_acc, last_t, done_t, ov_cnt, last_cnt;
    n = 0; k = 1; last_acc = -1; last_t = -1; done_t = -1; ov_cnt = 0; last_cnt = 0;
    next_cycle();
    start    = 1'b1;
    width    = COL_W'(w);
    height   = ROW_W'(h);
    in_valid = 1'b0;
    next_cycle();
    start    = 1'b0;
    in_valid = 1'b1;
    while (done_t < 0 && k < w * h + 20) begin
      @(negedge clock);
      if (in_ready && in_valid) begin
        total++;
        if (col !== COL_W'(n % w) || row !== ROW_W'(n / w)) begin
          bad++;
          $display("FAIL cont%0dx%0d_pos acc=%0d: got col=%0d row=%0d want col=%0d row=%0d", w, h, n, col, row, n % w, n / w);
        end
        n++;
        last_acc = k;
      end
      if (out_valid) ov_cnt++;
      if (out_valid && out_last) begin
        last_cnt++;
        last_t = k;
      end
      if (frame_done) done_t = k;
      next_cycle();
      in_valid = (done_t < 0);
      k++;
    end
    in_valid = 1'b0;
    total++;
    if (done_t < 0) begin
      bad++;
      $display("FAIL cont%0dx%0d_timeout: got no frame_done within %0d cycles", w, h, w * h + 20);
    end
    total++;
    if (n != w * h || ov_cnt != w * h) begin
      bad++;
      $display("FAIL cont%0dx%0d_counts: got accepts=%0d out_valid=%0d want %0d", w, h, n, ov_cnt, w * h);
    end
    total++;
    if (last_cnt != 1 || last_t != last_acc + LAT) begin
      bad++;
      $display("FAIL cont%0dx%0d_last: got count=%0d at=%0d want 1 at %0d", w, h, last_cnt, last_t, last_acc + LAT);
    end
    total++;
    if (done_t != last_acc + LAT + 1) begin
      bad++;
      $display("FAIL cont%0dx%0d_done: got at=%0d want %0d", w, h, done_t, last_acc + LAT + 1);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k <= 6; k++) begin
      next_cycle();
      start    = (k == 0);
      width    = 10'd4;
      height   = 10'd3;
      in_valid = (k >= 1);
      reset    = (k == 6);
      @(negedge clock);
      if (k == 6) begin
        total++;
        if (col !== 10'd1 || row !== 10'd1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL abort_pre: got col=%0d row=%0d busy=%b want 1 1 1", col, row, busy);
        end
      end
    end
    next_cycle();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    total++;
    if ({in_ready, col, row, core_on_edge, out_valid, out_last, busy, frame_done, cfg_err, stall_count} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got ready=%b col=%0d row=%0d edge=%b ov=%b last=%b busy=%b done=%b stall=%0d, want all 0",
               in_ready, col, row, core_on_edge, out_valid, out_last, busy, frame_done, stall_count);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clock);
      total++;
      if ({out_valid, frame_done, busy} !== 3'b000) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d: got {ov,done,busy}=%b want 000", k, {out_valid, frame_done, busy});
      end
    end
    run_frame_cont(3, 3);
  endtask

  task automatic test_start_ignored();
    int acc, done_cnt, done_t, err_cnt;
    acc = 0; done_cnt = 0; done_t = -1; err_cnt = 0;
    for (int k = 0; k <= 16; k++) begin
      next_cycle();
      start    = (k == 0 || k == 4 || k == 10 || k == 12);
      width    = (k == 0) ? 10'd3 : (k == 4) ? 10'd5 : 10'd2;
      height   = (k == 0) ? 10'd3 : (k == 4) ? 10'd5 : 10'd2;
      in_valid = (k >= 1 && k <= 9);
      @(negedge clock);
      if (in_ready && in_valid) acc++;
      if (frame_done) begin
        done_cnt++;
        done_t = k;
      end
      if (cfg_err) err_cnt++;
      if (k == 11) begin
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL ignore_drain: got busy=%b ready=%b want 1 0", busy, in_ready);
        end
      end
    end
    start = 1'b0;
    total++;
    if (acc != 9 || done_cnt != 1 || done_t != 12) begin
      bad++;
      $display("FAIL ignore_start: got accepts=%0d dones=%0d done_at=%0d want 9 1 12", acc, done_cnt, done_t);
    end
    total++;
    if (err_cnt != 0) begin
      bad++;
      $display("FAIL ignore_cfg_err: got %0d pulses want 0", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_err(2, 5);
    test_cfg_err(5, 2);
    test_frame_4x3();
    test_gaps();
    run_frame_cont(640, 3);
    run_frame_cont(3, 480);
    test_reset_mid_run();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
